// File: rtl/stall_fifo_buffer_if.sv
// Handshake bundle for stall_fifo_buffer: the upstream word and controls,
// plus the buffered output word and fill/status flags.
interface stall_fifo_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             stall;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             almost_full;
  logic             overflow;

  modport slave (
    input  flush, stall, in_valid, in_data,
    output out_valid, out_data, count, full, almost_full, overflow
  );

  modport master (
    output flush, stall, in_valid, in_data,
    input  out_valid, out_data, count, full, almost_full, overflow
  );
endinterface

// File: rtl/stall_fifo_buffer.sv
// Circular stall buffer: absorbs words while the pipeline is stalled and
// drains them in order afterwards, one per cycle, with fill/overflow status.
module stall_fifo_buffer #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter bit BYPASS    = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  stall_fifo_buffer_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    OP_FLUSH,
    OP_STALL,
    OP_DRAIN,
    OP_BYPASS,
    OP_ENQUEUE
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, full;
  op_e              op;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full = (count_q == CW'(DEPTH));

  always_comb begin
    if (bus.flush)              op = OP_FLUSH;
    else if (bus.stall)         op = OP_STALL;
    else if (count_q != '0)     op = OP_DRAIN;
    else if (BYPASS)            op = OP_BYPASS;
    else                        op = OP_ENQUEUE;
  end

  always_comb begin
    push        = 1'b0;
    pop         = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    unique case (op)
      OP_FLUSH: begin
        out_data_d = '0;
        overflow_d = 1'b0;
      end
      OP_STALL: begin
        if (bus.in_valid) begin
          if (full) overflow_d = 1'b1;
          else      push       = 1'b1;
        end
      end
      OP_DRAIN: begin
        pop         = 1'b1;
        push        = bus.in_valid;
        out_valid_d = 1'b1;
        out_data_d  = mem_q[head_q];
      end
      OP_BYPASS: begin
        out_valid_d = bus.in_valid;
        out_data_d  = bus.in_data;
      end
      OP_ENQUEUE: begin
        push = bus.in_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    head_d  = pop  ? ptr_inc(head_q) : head_q;
    tail_d  = push ? ptr_inc(tail_q) : tail_q;
    count_d = count_q;
    if (op == OP_FLUSH) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= bus.in_data;
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.almost_full = (count_q >= CW'(AF_THRESH));
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_stall_fifo_buffer.sv
// Directed bench for stall_fifo_buffer: default build plus a DEPTH=5,
// BYPASS=0 build for pointer wrap under random stall.
module tb_stall_fifo_buffer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  stall_fifo_buffer_if #(.WIDTH(32), .DEPTH(8)) bus ();
  stall_fifo_buffer_if #(.WIDTH(32), .DEPTH(5)) bus5 ();

  stall_fifo_buffer #(.WIDTH(32), .DEPTH(8), .AF_THRESH(6), .BYPASS(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  stall_fifo_buffer #(.WIDTH(32), .DEPTH(5), .AF_THRESH(4), .BYPASS(1'b0)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, sent, rx, cnt_before;
    bit st, iv, exp_ov;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.flush = 0; bus.stall = 0; bus.in_valid = 0; bus.in_data = '0;
    bus5.flush = 0; bus5.stall = 0; bus5.in_valid = 0; bus5.in_data = '0;
    step(); step();
    chk("rst_count", bus.count, 0);
    chk("rst_ovalid", bus.out_valid, 0);
    reset = 1'b0;

    // Test 1: load state, then async reset mid-cycle
    bus.in_valid = 1; bus.in_data = 32'h55;
    step();
    chk("t1_byp_valid", bus.out_valid, 1);
    chk("t1_byp_data", bus.out_data, 32'h55);
    bus.stall = 1; bus.in_data = 32'h66;
    step();
    chk("t1_stall_count", bus.count, 1);
    chk("t1_stall_ovalid", bus.out_valid, 0);
    chk("t1_stall_hold", bus.out_data, 32'h55);
    bus.stall = 0; bus.in_valid = 0;
    #2 reset = 1'b1;
    #1;
    chk("t1_async_ovalid", bus.out_valid, 0);
    chk("t1_async_odata", bus.out_data, 0);
    chk("t1_async_count", bus.count, 0);
    chk("t1_async_full", bus.full, 0);
    chk("t1_async_ovf", bus.overflow, 0);
    #1 reset = 1'b0;
    step();

    // Test 2: bypass latency 1
    bus.in_valid = 1; bus.in_data = 32'hA1;
    step();
    chk("t2_ovalid", bus.out_valid, 1);
    chk("t2_odata", bus.out_data, 32'hA1);
    chk("t2_count", bus.count, 0);
    bus.in_valid = 0;
    step();
    chk("t2_idle_ovalid", bus.out_valid, 0);

    // Test 3: fill under stall, then overflow
    bus.stall = 1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1; bus.in_data = 32'h10 + i;
      step();
      chk("t3_count", bus.count, i + 1);
      chk("t3_af", bus.almost_full, (i >= 5) ? 1 : 0);
      chk("t3_full", bus.full, (i == 7) ? 1 : 0);
      chk("t3_ovalid", bus.out_valid, 0);
    end
    chk("t3_ovf_before", bus.overflow, 0);
    bus.in_data = 32'hFF;
    step();
    chk("t3_ovf", bus.overflow, 1);
    chk("t3_count_ovf", bus.count, 8);
    chk("t3_full_ovf", bus.full, 1);

    // Test 4: drain while pushing 0x20..0x23
    bus.stall = 0;
    for (int k = 0; k < 12; k++) begin
      bus.in_valid = (k < 4);
      bus.in_data  = 32'h20 + k;
      step();
      chk("t4_ovalid", bus.out_valid, 1);
      chk("t4_odata", bus.out_data, (k < 8) ? (32'h10 + k) : (32'h20 + k - 8));
      chk("t4_count", bus.count, (k < 4) ? 8 : (11 - k));
    end
    bus.in_valid = 0;
    step();
    chk("t4_empty_ovalid", bus.out_valid, 0);
    chk("t4_empty_count", bus.count, 0);
    chk("t4_ovf_sticky", bus.overflow, 1);

    // Test 5: flush mid-drain with in_valid asserted
    bus.stall = 1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1; bus.in_data = 32'h30 + i;
      step();
    end
    bus.stall = 0; bus.in_valid = 0;
    step();
    chk("t5_pre_data", bus.out_data, 32'h30);
    chk("t5_pre_count", bus.count, 5);
    bus.flush = 1; bus.in_valid = 1; bus.in_data = 32'hEE;
    step();
    chk("t5_count", bus.count, 0);
    chk("t5_ovalid", bus.out_valid, 0);
    chk("t5_odata", bus.out_data, 0);
    chk("t5_ovf", bus.overflow, 0);
    bus.flush = 0; bus.in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_emerge", bus.out_valid, 0);
    end

    // Test 6: DEPTH=5, BYPASS=0, random stall, 40 words in order
    cnt = 0; sent = 0; rx = 0;
    for (int cyc = 0; cyc < 1000 && rx < 40; cyc++) begin
      st = 1'($urandom_range(0, 1));
      iv = (sent < 40) && (!st || cnt < 5) && ($urandom_range(0, 3) != 0);
      bus5.stall = st; bus5.in_valid = iv; bus5.in_data = 32'h100 + sent;
      cnt_before = cnt;
      exp_ov = !st && (cnt_before > 0);
      if (st) begin
        if (iv) cnt++;
      end else if (cnt_before > 0) begin
        if (!iv) cnt--;
      end else if (iv) begin
        cnt = 1;
      end
      if (iv) sent++;
      step();
      chk("t6_count", bus5.count, cnt);
      chk("t6_le5", (bus5.count <= 3'd5), 1);
      chk("t6_ovalid", bus5.out_valid, exp_ov);
      if (exp_ov) begin
        chk("t6_odata", bus5.out_data, 32'h100 + rx);
        rx++;
      end
    end
    chk("t6_all_received", rx, 40);
    chk("t6_ovf", bus5.overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
